// File: rtl/seg_scan_decoder_pkg.sv
// ----------------------------------------------------------------------------
// seg_scan_decoder_pkg
// Shared constants and types for the seven-segment scan decoder:
//   - NUM_DIGITS          number of multiplexed digits on the bus
//   - DP_BIT / SEG_MSB    bit-field positions inside dispcode
//   - SEG_HEX             active-high gfedcba patterns for hex digits 0..F
//   - sample_class_t      classification of one synchronised bus sample
//   - count_selects()     number of active digit selects in a sample
// ----------------------------------------------------------------------------
package seg_scan_decoder_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int DP_BIT     = 7;
    localparam int SEG_MSB    = 6;

    // Index i holds the lit-segment pattern for hex digit i.
    // Written MSB-first, so the last entry is digit 0.
    localparam logic [15:0][6:0] SEG_HEX = {
        7'h71, // F
        7'h79, // E
        7'h5E, // d
        7'h39, // C
        7'h7C, // b
        7'h77, // A
        7'h6F, // 9
        7'h7F, // 8
        7'h07, // 7
        7'h7D, // 6
        7'h6D, // 5
        7'h66, // 4
        7'h4F, // 3
        7'h5B, // 2
        7'h06, // 1
        7'h3F  // 0
    };

    typedef enum logic [1:0] {
        CLASS_GAP   = 2'd0,
        CLASS_DIGIT = 2'd1,
        CLASS_MULTI = 2'd2
    } sample_class_t;

    // Counts how many digit selects are active in one normalised sample.
    function automatic logic [2:0] count_selects(input logic [NUM_DIGITS-1:0] sel);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            n = n + {2'b00, sel[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/seg_scan_decoder_if.sv
// ----------------------------------------------------------------------------
// seg_scan_decoder_if
// Bundles the monitored display bus and the decoded results.
//   dispcode[7:0]   segment bus, [7]=dp, [6:0]=gfedcba (raw pin polarity)
//   sign_1..sign_4  digit selects (raw pin polarity), sign_1 = least significant
//   err_clr         synchronous clear of the sticky error flags
//   value[15:0]     last completed frame, four hex digits
//   dp[3:0]         decimal points of the last frame, bit i = sign_(i+1)
//   frame_valid     one-cycle pulse when value/dp update
//   err_pattern     sticky: a stable pattern that is not a hex digit was seen
//   err_multi       sticky: more than one digit select was active at once
// master = the side that drives the display bus; slave = the decoder.
// ----------------------------------------------------------------------------
interface seg_scan_decoder_if;

    logic [7:0]  dispcode;
    logic        sign_1;
    logic        sign_2;
    logic        sign_3;
    logic        sign_4;
    logic        err_clr;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        frame_valid;
    logic        err_pattern;
    logic        err_multi;

    modport master (
        output dispcode, sign_1, sign_2, sign_3, sign_4, err_clr,
        input  value, dp, frame_valid, err_pattern, err_multi
    );

    modport slave (
        input  dispcode, sign_1, sign_2, sign_3, sign_4, err_clr,
        output value, dp, frame_valid, err_pattern, err_multi
    );

endinterface

// File: rtl/seg_scan_decoder_seg7_to_hex.sv
// ----------------------------------------------------------------------------
// seg7_to_hex
// Combinational reverse lookup of an active-high gfedcba pattern.
//   seg[6:0]     lit segments, bit 0 = a ... bit 6 = g
//   hit          1 when seg matches one of the sixteen hex glyphs
//   nibble[3:0]  matching hex value (0 when there is no hit)
// ----------------------------------------------------------------------------
module seg7_to_hex
    import seg_scan_decoder_pkg::*;
(
    input  logic [6:0] seg,
    output logic       hit,
    output logic [3:0] nibble
);

    // Scan the glyph table; the glyphs are all distinct, so at most one
    // entry can match and the loop order does not matter.
    always_comb begin
        hit    = 1'b0;
        nibble = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (seg == SEG_HEX[i]) begin
                hit    = 1'b1;
                nibble = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// ----------------------------------------------------------------------------
// seg_scan_decoder
// Monitors a multiplexed 4-digit seven-segment display bus, accepts each digit
// once it has been stable for STABLE_CYCLES synchronised samples, decodes it
// back to a hex nibble plus decimal point and publishes a full frame once all
// four digits have been captured.
//   clk   system clock
//   rst   asynchronous active-high reset
//   bus   seg_scan_decoder_if.slave (display bus in, decoded frame/errors out)
// Parameters:
//   STABLE_CYCLES   identical synchronised samples needed to accept a digit
//   SEG_ACTIVE_LOW  1: a low dispcode bit lights the segment
//   SEL_ACTIVE_LOW  1: a low sign_x selects the digit
// ----------------------------------------------------------------------------
module seg_scan_decoder
    import seg_scan_decoder_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit SEL_ACTIVE_LOW = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    seg_scan_decoder_if.slave   bus
);

    localparam int              CW       = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_MAX  = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [7:0]      SEG_IDLE = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] SEL_IDLE = SEL_ACTIVE_LOW ? '1 : '0;

    logic [7:0]             seg_s1, seg_s2;
    logic [NUM_DIGITS-1:0]  sel_s1, sel_s2;
    logic [NUM_DIGITS-1:0]  sel_raw;
    logic [7:0]             seg_n;
    logic [NUM_DIGITS-1:0]  sel_n;

    sample_class_t          sample_class;
    logic [1:0]             digit_idx;

    logic [7:0]             prev_seg;
    logic [NUM_DIGITS-1:0]  prev_sel;
    logic [CW-1:0]          cnt, cnt_next;
    logic                   accepted, accepted_next;
    logic                   accept;

    logic                   dec_hit;
    logic [3:0]             dec_nibble;

    logic [NUM_DIGITS-1:0][3:0] shadow, shadow_merged;
    logic [NUM_DIGITS-1:0]      shadow_dp, dp_merged;
    logic [NUM_DIGITS-1:0]      mask, mask_merged;
    logic                       frame_done;

    logic [15:0]            value_r;
    logic [NUM_DIGITS-1:0]  dp_r;
    logic                   frame_valid_r;
    logic                   err_pattern_r;
    logic                   err_multi_r;

    assign sel_raw = {bus.sign_4, bus.sign_3, bus.sign_2, bus.sign_1};

    // Two-flop synchroniser for the asynchronous display pins. The flops reset
    // to the idle bus level so that the first samples after reset read as a
    // gap rather than as every digit selected at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_s1 <= SEG_IDLE;
            seg_s2 <= SEG_IDLE;
            sel_s1 <= SEL_IDLE;
            sel_s2 <= SEL_IDLE;
        end else begin
            seg_s1 <= bus.dispcode;
            seg_s2 <= seg_s1;
            sel_s1 <= sel_raw;
            sel_s2 <= sel_s1;
        end
    end

    // Everything downstream works on active-high segments and selects.
    assign seg_n = SEG_ACTIVE_LOW ? ~seg_s2 : seg_s2;
    assign sel_n = SEL_ACTIVE_LOW ? ~sel_s2 : sel_s2;

    // Classify the current synchronised sample. Several selects at once is
    // reported as MULTI even when the segments are dark, since it is a bus
    // fault regardless of what is being shown.
    always_comb begin
        sample_class = CLASS_GAP;
        if (count_selects(sel_n) > 3'd1) begin
            sample_class = CLASS_MULTI;
        end else if (sel_n != '0 && seg_n[SEG_MSB:0] != 7'h00) begin
            sample_class = CLASS_DIGIT;
        end
    end

    // Position of the single active select; only meaningful for DIGIT samples.
    always_comb begin
        digit_idx = 2'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel_n[i]) begin
                digit_idx = 2'(i);
            end
        end
    end

    // Stability tracking. A DIGIT sample identical to the previous one extends
    // the dwell (saturating), a different DIGIT starts a new dwell at one, and
    // any GAP or MULTI ends the dwell. The accepted flag limits each dwell to
    // a single accept, so a digit held for a long time is decoded only once.
    always_comb begin
        cnt_next      = cnt;
        accepted_next = accepted;
        accept        = 1'b0;
        case (sample_class)
            CLASS_DIGIT: begin
                if (cnt != '0 && sel_n == prev_sel && seg_n == prev_seg) begin
                    if (cnt != CNT_MAX) begin
                        cnt_next = cnt + CNT_ONE;
                    end
                end else begin
                    cnt_next      = CNT_ONE;
                    accepted_next = 1'b0;
                end
                if (cnt_next == CNT_MAX && !accepted_next) begin
                    accept        = 1'b1;
                    accepted_next = 1'b1;
                end
            end
            default: begin
                cnt_next      = '0;
                accepted_next = 1'b0;
            end
        endcase
    end

    // Dwell state registers: the previous sample for comparison, the
    // stability counter and the one-accept-per-dwell flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_seg <= '0;
            prev_sel <= '0;
            cnt      <= '0;
            accepted <= 1'b0;
        end else begin
            prev_seg <= seg_n;
            prev_sel <= sel_n;
            cnt      <= cnt_next;
            accepted <= accepted_next;
        end
    end

    seg7_to_hex u_seg7_to_hex (
        .seg    (seg_n[SEG_MSB:0]),
        .hit    (dec_hit),
        .nibble (dec_nibble)
    );

    // Merge a successfully decoded digit into the shadow frame. The merged
    // view is what gets published, so the digit that completes a frame is
    // already part of the value that appears one cycle later.
    always_comb begin
        shadow_merged = shadow;
        dp_merged     = shadow_dp;
        mask_merged   = mask;
        if (accept && dec_hit) begin
            shadow_merged[digit_idx] = dec_nibble;
            dp_merged[digit_idx]     = seg_n[DP_BIT];
            mask_merged[digit_idx]   = 1'b1;
        end
    end

    assign frame_done = accept && dec_hit && (mask_merged == '1);

    // Shadow frame and capture mask. The mask restarts as soon as a frame is
    // published; shadow contents are simply overwritten by later accepts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow    <= '0;
            shadow_dp <= '0;
            mask      <= '0;
        end else begin
            shadow    <= shadow_merged;
            shadow_dp <= dp_merged;
            mask      <= frame_done ? '0 : mask_merged;
        end
    end

    // Published frame, strobe and sticky error flags. A new error event in
    // the same cycle as err_clr wins, so no event can be lost to a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_r       <= '0;
            dp_r          <= '0;
            frame_valid_r <= 1'b0;
            err_pattern_r <= 1'b0;
            err_multi_r   <= 1'b0;
        end else begin
            frame_valid_r <= frame_done;
            if (frame_done) begin
                value_r <= shadow_merged;
                dp_r    <= dp_merged;
            end
            err_pattern_r <= (accept && !dec_hit) || (err_pattern_r && !bus.err_clr);
            err_multi_r   <= (sample_class == CLASS_MULTI) || (err_multi_r && !bus.err_clr);
        end
    end

    assign bus.value       = value_r;
    assign bus.dp          = dp_r;
    assign bus.frame_valid = frame_valid_r;
    assign bus.err_pattern = err_pattern_r;
    assign bus.err_multi   = err_multi_r;

endmodule
